// File: rtl/bus_arbiter_if.sv
// ============================================================================
// Module : bus_arbiter_if
// Brief  : Host-side and device-side bus bundle for the multi-host arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_arbiter_if #(
   parameter int NR_HOSTS   = 2,
   parameter int NR_DEVICES = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   // Suffixes are from the arbiter's point of view.
   logic [NR_HOSTS-1:0]              host_req_i;
   logic [NR_HOSTS-1:0]              host_we_i;
   logic [NR_HOSTS*ADDR_WIDTH-1:0]   host_addr_i;
   logic [NR_HOSTS*DATA_WIDTH-1:0]   host_wdata_i;
   logic [NR_HOSTS-1:0]              host_gnt_o;
   logic [NR_HOSTS-1:0]              host_rvalid_o;
   logic [NR_HOSTS-1:0]              host_err_o;
   logic [NR_HOSTS*DATA_WIDTH-1:0]   host_rdata_o;
   logic [NR_DEVICES-1:0]            device_req_o;
   logic                             device_we_o;
   logic [ADDR_WIDTH-1:0]            device_addr_o;
   logic [DATA_WIDTH-1:0]            device_wdata_o;
   logic [NR_DEVICES*DATA_WIDTH-1:0] device_rdata_i;
   logic [NR_DEVICES*ADDR_WIDTH-1:0] cfg_device_addr_base_i;
   logic [NR_DEVICES*ADDR_WIDTH-1:0] cfg_device_addr_mask_i;

   modport slave (
      input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
      input  device_rdata_i, cfg_device_addr_base_i, cfg_device_addr_mask_i,
      output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
      output device_req_o, device_we_o, device_addr_o, device_wdata_o
   );

   modport master (
      output host_req_i, host_we_i, host_addr_i, host_wdata_i,
      output device_rdata_i, cfg_device_addr_base_i, cfg_device_addr_mask_i,
      input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
      input  device_req_o, device_we_o, device_addr_o, device_wdata_o
   );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module : bus_arbiter
// Brief  : Round-robin multi-host memory bus arbiter with base/mask decode and
//          a one-cycle registered response stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
   parameter int NR_HOSTS   = 2,
   parameter int NR_DEVICES = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  wire logic    clk_i,
   input  wire logic    rst_i,
   bus_arbiter_if.slave bus
);

   localparam int c_HOST_W = (NR_HOSTS > 1) ? $clog2(NR_HOSTS) : 1;
   localparam int c_DEV_W  = (NR_DEVICES > 1) ? $clog2(NR_DEVICES) : 1;
   localparam logic [c_HOST_W-1:0] c_LAST_HOST = c_HOST_W'(NR_HOSTS - 1);

   logic [c_HOST_W-1:0]   r_rr_ptr;
   logic                  r_rsp_valid;
   logic [c_HOST_W-1:0]   r_rsp_host;
   logic [c_DEV_W-1:0]    r_rsp_dev;
   logic                  r_rsp_err;
   logic                  r_rsp_we;

   logic                  w_found;
   logic                  w_grant;
   logic [c_HOST_W-1:0]   w_winner;
   logic [c_HOST_W-1:0]   w_ptr_next;
   int                    w_idx;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] w_mask;
   logic                  w_we;
   logic                  w_hit;
   logic [c_DEV_W-1:0]    w_dev;

   // Rotating priority search starting at r_rr_ptr.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = 0;
      for (int i = 0; i < NR_HOSTS; i++) begin
         w_idx = int'(r_rr_ptr) + i;
         if (w_idx >= NR_HOSTS) w_idx = w_idx - NR_HOSTS;
         if (!w_found && bus.host_req_i[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx[c_HOST_W-1:0];
         end
      end
      w_grant    = w_found & rst_i;
      w_ptr_next = (w_winner == c_LAST_HOST) ? '0 : w_winner + 1'b1;
   end

   always_comb begin
      w_addr = bus.host_addr_i[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
      w_we   = bus.host_we_i[w_winner];
      w_hit  = 1'b0;
      w_dev  = '0;
      w_mask = '0;
      for (int d = 0; d < NR_DEVICES; d++) begin
         w_mask = bus.cfg_device_addr_mask_i[d*ADDR_WIDTH +: ADDR_WIDTH];
         if (!w_hit && ((w_addr & w_mask) ==
             (bus.cfg_device_addr_base_i[d*ADDR_WIDTH +: ADDR_WIDTH] & w_mask))) begin
            w_hit = 1'b1;
            w_dev = c_DEV_W'(d);
         end
      end
   end

   always_comb begin
      bus.host_gnt_o     = '0;
      bus.device_req_o   = '0;
      bus.device_we_o    = 1'b0;
      bus.device_addr_o  = '0;
      bus.device_wdata_o = '0;
      if (w_grant) begin
         bus.host_gnt_o[w_winner] = 1'b1;
         bus.device_we_o          = w_we;
         bus.device_addr_o        = w_addr;
         bus.device_wdata_o       = bus.host_wdata_i[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
         if (w_hit) bus.device_req_o[w_dev] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_rr_ptr    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_host  <= '0;
         r_rsp_dev   <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_we    <= 1'b0;
      end else begin
         if (w_grant) r_rr_ptr <= w_ptr_next;
         r_rsp_valid <= w_grant;
         r_rsp_host  <= w_winner;
         r_rsp_dev   <= w_dev;
         r_rsp_err   <= !w_hit;
         r_rsp_we    <= w_we;
      end
   end

   // Non-responding host slices stay at zero; writes and errors return zero data.
   always_comb begin
      bus.host_rvalid_o = '0;
      bus.host_err_o    = '0;
      bus.host_rdata_o  = '0;
      if (r_rsp_valid) begin
         bus.host_rvalid_o[r_rsp_host] = 1'b1;
         bus.host_err_o[r_rsp_host]    = r_rsp_err;
         if (!r_rsp_err && !r_rsp_we) begin
            bus.host_rdata_o[int'(r_rsp_host)*DATA_WIDTH +: DATA_WIDTH] =
               bus.device_rdata_i[int'(r_rsp_dev)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module : tb_bus_arbiter
// Brief  : Self-checking bench for bus_arbiter with a response scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

   localparam logic [31:0] c_RAM_DATA = 32'hDEADBEEF;
   localparam logic [31:0] c_CON_DATA = 32'hC0C00001;
   localparam logic [31:0] c_CLT_DATA = 32'h0C110002;

   typedef struct {
      int          host;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   logic clk;
   logic rst_i;
   int   errors;
   int   checks;
   int   m_ptr;
   rsp_t sb[$];
   rsp_t e;
   logic [1:0]  exp_rv, exp_err;
   logic [63:0] exp_rd;

   bus_arbiter_if #(.NR_HOSTS(2), .NR_DEVICES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   bus_arbiter #(.NR_HOSTS(2), .NR_DEVICES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] model_gnt(logic [1:0] req, int ptr);
      for (int i = 0; i < 2; i++) begin
         if (req[(ptr + i) % 2]) return 2'b01 << ((ptr + i) % 2);
      end
      return 2'b00;
   endfunction

   function automatic logic [2:0] model_dev(logic [31:0] a);
      if ((a & ~32'h001FFFFF) == 32'h0)        return 3'b001;
      if ((a & ~32'h000FFFFF) == 32'h00200000) return 3'b010;
      if ((a & ~32'h0000FFFF) == 32'h02000000) return 3'b100;
      return 3'b000;
   endfunction

   task automatic drive(logic [1:0] req, logic [1:0] we, logic [31:0] a0, logic [31:0] a1);
      bus.host_req_i   = req;
      bus.host_we_i    = we;
      bus.host_addr_i  = {a1, a0};
      bus.host_wdata_i = {a1 ^ 32'h5A5A5A5A, a0 ^ 32'hA5A5A5A5};
   endtask

   // Records the expected response of the current cycle's grant, then steps a clock.
   task automatic advance();
      logic [1:0] g;
      logic [2:0] dv;
      rsp_t r;
      g = model_gnt(bus.host_req_i, m_ptr);
      if (g != 2'b00) begin
         r.host  = g[1] ? 1 : 0;
         dv      = model_dev(bus.host_addr_i[r.host*32 +: 32]);
         r.err   = (dv == 3'b000);
         r.rdata = (bus.host_we_i[r.host] || r.err) ? 32'h0 :
                   (dv == 3'b001) ? c_RAM_DATA : (dv == 3'b010) ? c_CON_DATA : c_CLT_DATA;
         sb.push_back(r);
         m_ptr = (r.host + 1) % 2;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_i = 1'b0;
      sb.delete();
      m_ptr = 0;
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      drive(2'b11, 2'b00, 32'h100, 32'h100);
      #1;
      checks++;
      if (bus.host_gnt_o !== 2'b00 || bus.device_req_o !== 3'b000) begin
         errors++;
         $display("FAIL reset_gnt: gnt=%b dev_req=%b, expected 00/000", bus.host_gnt_o, bus.device_req_o);
      end
      checks++;
      if (bus.host_rvalid_o !== 2'b00 || bus.host_err_o !== 2'b00 || bus.host_rdata_o !== 64'h0) begin
         errors++;
         $display("FAIL reset_rsp: rvalid=%b err=%b rdata=%h, expected zeros",
                  bus.host_rvalid_o, bus.host_err_o, bus.host_rdata_o);
      end
      drive(2'b00, 2'b00, 32'h0, 32'h0);
      @(negedge clk);
      rst_i = 1'b1;
      m_ptr = 0;
   endtask

   task automatic test_decode();
      logic [1:0]  we_t [4] = '{2'b00, 2'b01, 2'b00, 2'b00};
      logic [31:0] ad_t [4] = '{32'h00000100, 32'h00200004, 32'h02000008, 32'h0};
      logic [2:0]  dv_t [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
      for (int i = 0; i < 4; i++) begin
         drive((i < 3) ? 2'b01 : 2'b00, we_t[i], ad_t[i], 32'h0);
         #1;
         exp_rv = '0; exp_err = '0; exp_rd = '0;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv[e.host] = 1'b1; exp_err[e.host] = e.err; exp_rd[e.host*32 +: 32] = e.rdata;
         end
         checks++;
         if (bus.host_rvalid_o !== exp_rv || bus.host_err_o !== exp_err || bus.host_rdata_o !== exp_rd) begin
            errors++;
            $display("FAIL decode_rsp[%0d]: rvalid=%b err=%b rdata=%h, expected %b %b %h", i,
                     bus.host_rvalid_o, bus.host_err_o, bus.host_rdata_o, exp_rv, exp_err, exp_rd);
         end
         checks++;
         if (bus.device_req_o !== dv_t[i] || bus.host_gnt_o !== ((i < 3) ? 2'b01 : 2'b00) ||
             bus.device_we_o !== we_t[i][0] || bus.device_addr_o !== ((i < 3) ? ad_t[i] : 32'h0)) begin
            errors++;
            $display("FAIL decode_req[%0d]: gnt=%b dev_req=%b we=%b addr=%h, expected dev_req=%b we=%b addr=%h",
                     i, bus.host_gnt_o, bus.device_req_o, bus.device_we_o, bus.device_addr_o,
                     dv_t[i], we_t[i][0], ad_t[i]);
         end
         if (i == 1) begin
            checks++;
            if (bus.device_wdata_o !== (32'h00200004 ^ 32'hA5A5A5A5)) begin
               errors++;
               $display("FAIL decode_wdata: got %h, expected %h", bus.device_wdata_o, 32'h00200004 ^ 32'hA5A5A5A5);
            end
         end
         advance();
      end
   endtask

   task automatic test_read_latency();
      logic [1:0] g_t  [3] = '{2'b01, 2'b00, 2'b00};
      logic [1:0] rv_t [3] = '{2'b00, 2'b01, 2'b00};
      for (int i = 0; i < 3; i++) begin
         drive(g_t[i], 2'b00, 32'h100, 32'h0);
         #1;
         exp_rv = '0; exp_err = '0; exp_rd = '0;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv[e.host] = 1'b1; exp_err[e.host] = e.err; exp_rd[e.host*32 +: 32] = e.rdata;
         end
         checks++;
         if (bus.host_rvalid_o !== rv_t[i] || bus.host_rvalid_o !== exp_rv ||
             bus.host_rdata_o !== exp_rd || bus.host_gnt_o !== g_t[i]) begin
            errors++;
            $display("FAIL latency[%0d]: gnt=%b rvalid=%b rdata=%h, expected gnt=%b rvalid=%b rdata=%h",
                     i, bus.host_gnt_o, bus.host_rvalid_o, bus.host_rdata_o, g_t[i], rv_t[i], exp_rd);
         end
         advance();
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] g_t [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         drive((i < 4) ? 2'b11 : 2'b00, 2'b00, 32'h100, 32'h200010);
         #1;
         exp_rv = '0; exp_err = '0; exp_rd = '0;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv[e.host] = 1'b1; exp_err[e.host] = e.err; exp_rd[e.host*32 +: 32] = e.rdata;
         end
         checks++;
         if (bus.host_rvalid_o !== exp_rv || bus.host_err_o !== exp_err || bus.host_rdata_o !== exp_rd) begin
            errors++;
            $display("FAIL rr_rsp[%0d]: rvalid=%b err=%b rdata=%h, expected %b %b %h", i,
                     bus.host_rvalid_o, bus.host_err_o, bus.host_rdata_o, exp_rv, exp_err, exp_rd);
         end
         checks++;
         if (bus.host_gnt_o !== g_t[i]) begin
            errors++;
            $display("FAIL rr_gnt[%0d]: gnt=%b, expected %b", i, bus.host_gnt_o, g_t[i]);
         end
         advance();
      end
   endtask

   task automatic test_decode_error();
      for (int i = 0; i < 2; i++) begin
         drive((i == 0) ? 2'b10 : 2'b00, 2'b00, 32'h0, 32'h10000000);
         #1;
         exp_rv = '0; exp_err = '0; exp_rd = '0;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv[e.host] = 1'b1; exp_err[e.host] = e.err; exp_rd[e.host*32 +: 32] = e.rdata;
         end
         checks++;
         if (bus.host_rvalid_o !== exp_rv || bus.host_err_o !== exp_err || bus.host_rdata_o !== exp_rd ||
             (i == 1 && bus.host_err_o !== 2'b10)) begin
            errors++;
            $display("FAIL decerr_rsp[%0d]: rvalid=%b err=%b rdata=%h, expected %b %b %h", i,
                     bus.host_rvalid_o, bus.host_err_o, bus.host_rdata_o, exp_rv, exp_err, exp_rd);
         end
         checks++;
         if (bus.host_gnt_o !== ((i == 0) ? 2'b10 : 2'b00) || bus.device_req_o !== 3'b000) begin
            errors++;
            $display("FAIL decerr_req[%0d]: gnt=%b dev_req=%b, expected gnt=%b dev_req=000",
                     i, bus.host_gnt_o, bus.device_req_o, (i == 0) ? 2'b10 : 2'b00);
         end
         advance();
      end
   endtask

   task automatic test_single_requester();
      logic [1:0] r_t [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
      logic [1:0] g_t [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
      for (int i = 0; i < 5; i++) begin
         drive(r_t[i], 2'b00, 32'h100, 32'h00200000);
         #1;
         exp_rv = '0; exp_err = '0; exp_rd = '0;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv[e.host] = 1'b1; exp_err[e.host] = e.err; exp_rd[e.host*32 +: 32] = e.rdata;
         end
         checks++;
         if (bus.host_rvalid_o !== exp_rv || bus.host_err_o !== exp_err || bus.host_rdata_o !== exp_rd) begin
            errors++;
            $display("FAIL single_rsp[%0d]: rvalid=%b err=%b rdata=%h, expected %b %b %h", i,
                     bus.host_rvalid_o, bus.host_err_o, bus.host_rdata_o, exp_rv, exp_err, exp_rd);
         end
         checks++;
         if (bus.host_gnt_o !== g_t[i]) begin
            errors++;
            $display("FAIL single_gnt[%0d]: gnt=%b, expected %b", i, bus.host_gnt_o, g_t[i]);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      drive(2'b01, 2'b00, 32'h100, 32'h100);
      #1;
      checks++;
      if (bus.host_gnt_o !== 2'b01) begin
         errors++;
         $display("FAIL midrst_gnt: gnt=%b, expected 01", bus.host_gnt_o);
      end
      #1;
      rst_i = 1'b0;
      sb.delete();
      m_ptr = 0;
      drive(2'b00, 2'b00, 32'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.host_rvalid_o !== 2'b00) begin
         errors++;
         $display("FAIL midrst_hold: rvalid=%b, expected 00", bus.host_rvalid_o);
      end
      rst_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.host_rvalid_o !== 2'b00) begin
         errors++;
         $display("FAIL midrst_release: rvalid=%b, expected 00", bus.host_rvalid_o);
      end
      for (int i = 0; i < 2; i++) begin
         drive((i == 0) ? 2'b11 : 2'b00, 2'b00, 32'h100, 32'h02000000);
         #1;
         exp_rv = '0; exp_err = '0; exp_rd = '0;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv[e.host] = 1'b1; exp_err[e.host] = e.err; exp_rd[e.host*32 +: 32] = e.rdata;
         end
         checks++;
         if (bus.host_rvalid_o !== exp_rv || bus.host_rdata_o !== exp_rd ||
             bus.host_gnt_o !== ((i == 0) ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL midrst_after[%0d]: gnt=%b rvalid=%b rdata=%h, expected gnt=%b rvalid=%b rdata=%h",
                     i, bus.host_gnt_o, bus.host_rvalid_o, bus.host_rdata_o,
                     (i == 0) ? 2'b01 : 2'b00, exp_rv, exp_rd);
         end
         advance();
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      m_ptr  = 0;
      rst_i  = 1'b0;
      bus.device_rdata_i         = {c_CLT_DATA, c_CON_DATA, c_RAM_DATA};
      bus.cfg_device_addr_base_i = {32'h02000000, 32'h00200000, 32'h00000000};
      bus.cfg_device_addr_mask_i = {~32'h0000FFFF, ~32'h000FFFFF, ~32'h001FFFFF};
      drive(2'b00, 2'b00, 32'h0, 32'h0);
      @(negedge clk);
      test_reset();
      test_decode();
      test_read_latency();
      test_round_robin();
      test_decode_error();
      test_single_requester();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Multi-host interconnect controller for the SoC memory bus.
- Shares the device ports (RAM, console, CLINT) between NrHosts requesters, for example the core data port plus a debug or DMA host.
- Address decode uses the base/mask tables. Arbitration is round-robin, one transaction per cycle.
- A registered response stage matches the one-cycle read latency of dpram and clint.

Parameters:
- NrHosts, 2, number of requesting hosts (1..8)
- NrDevices, 3, number of target devices (1..8)
- DataWidth, 32, data bus width
- AddressWidth, 32, address bus width

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-low
- host_req_i  in  NrHosts  per-host request; held stable until granted
- host_we_i  in  NrHosts  per-host write enable
- host_addr_i  in  NrHosts*AddressWidth  host h address at slice [h*AW +: AW]
- host_wdata_i  in  NrHosts*DataWidth  per-host write data
- host_gnt_o  out  NrHosts  one-hot grant, combinational in the request cycle
- host_rvalid_o  out  NrHosts  response valid, one cycle after grant
- host_err_o  out  NrHosts  decode error, qualified by rvalid
- host_rdata_o  out  NrHosts*DataWidth  read data, qualified by rvalid
- device_req_o  out  NrDevices  one-hot device select
- device_we_o  out  1  write enable to the selected device
- device_addr_o  out  AddressWidth  granted host address, passed through unmodified
- device_wdata_o  out  DataWidth  granted host write data
- device_rdata_i  in  NrDevices*DataWidth  device read data, valid the cycle after device_req
- cfg_device_addr_base_i  in  NrDevices*AddressWidth  device base addresses
- cfg_device_addr_mask_i  in  NrDevices*AddressWidth  device masks

Behaviour:
- Reset (rst_i=0, asynchronous):
  - rr_ptr cleared to 0.
  - Response stage cleared.
  - host_rvalid_o=0, host_err_o=0, host_rdata_o=0.
  - host_gnt_o=0 and device_req_o=0 while rst_i is low.
- Arbitration (combinational):
  - Search starts at host rr_ptr and wraps modulo NrHosts.
  - The first host with host_req_i=1 wins; exactly one gnt bit is set. No request gives gnt=0.
  - After a grant to host k, rr_ptr <= (k+1) mod NrHosts on the next clock edge. With no grant, rr_ptr holds.
- Decode (combinational, on the winner's address):
  - Device d matches when (addr & mask[d]) == (base[d] & mask[d]).
  - If several devices match, the lowest index wins.
  - No match gives device_req_o=0 with the decode-error flag set. The grant is still issued.
- Device port:
  - With a grant and a match, device_req_o[d]=1, and device_we/addr/wdata are muxed from the winner.
  - With no grant, device_we_o=0, addr=0, wdata=0.
- Response stage (registered at grant):
  - Registers: rsp_valid, rsp_host, rsp_dev, rsp_err.
  - In cycle N+1 after a grant in cycle N:
    - host_rvalid_o[rsp_host]=1 for one cycle.
    - host_rdata_o slice = device_rdata_i[rsp_dev] for reads; 0 for writes or errors.
    - host_err_o[rsp_host]=rsp_err.
  - Writes also return an rvalid.
- Pipelining:
  - A new grant may be issued in cycle N+1 while the response for cycle N is being returned, giving a throughput of 1/cycle.
  - The same host may be granted back-to-back only if it is the sole requester.
- Boundary conditions:
  - All hosts requesting: strict rotation 0,1,...,N-1,0. No host waits more than NrHosts-1 cycles.
  - rr_ptr wraps from NrHosts-1 to 0.
  - NrHosts=1: gnt equals req, rr_ptr is constant 0.
  - Reset asserted with a response pending: the response is dropped and no rvalid is issued after reset release.
  - Base/mask configuration is treated as static. Changes take effect on the next grant; an in-flight response keeps its registered rsp_dev.
  - host_rdata_o slices of non-responding hosts are driven to 0.

Test Plan:
- Decode, NrHosts=2, cfg RAM 0x0/~0x1FFFFF, console 0x200000/~0xFFFFF, CLINT 0x2000000/~0xFFFF:
  - Host0 reads 0x00000100 -> device_req=3'b001.
  - Host0 writes 0x00200004 -> device_req=3'b010, we=1.
  - Host0 reads 0x02000008 -> device_req=3'b100.
- Read latency: host0 read of 0x100 with RAM rdata=0xDEADBEEF in the next cycle -> gnt[0] in cycle N; rvalid[0]=1 and rdata0=0xDEADBEEF in N+1; rvalid=0 in N+2.
- Round-robin: both hosts hold req for 4 cycles from reset -> gnt sequence 01,10,01,10; responses alternate rvalid[0], rvalid[1] one cycle later.
- Decode error: host1 reads 0x10000000 -> gnt[1]=1, device_req=0; next cycle rvalid[1]=1, err[1]=1, rdata1=0.
- Single requester: host1 alone for 3 cycles -> gnt=10 every cycle, 3 rvalids; next both request -> host0 granted first (rr_ptr=0 after wrap).
- Reset mid-operation: grant host0 read, pull rst_i low before the next edge -> rvalid stays 0, rr_ptr=0; after release the first grant goes to the lowest-index requester.
